// File: rtl/pulse_meter_pkg.sv
// ============================================================================
//  Module      : pulse_meter_pkg
//  Description : Shared state encoding and saturation helper for the
//                pulse period meter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_meter_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_e;

    // All-ones value of a counter of the given width (wraps correctly at 32).
    function automatic logic [31:0] f_sat_value(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/result_hold_reg.sv
// ============================================================================
//  Module      : result_hold_reg
//  Description : Single-entry valid/ready output register with overwrite and
//                sticky missed-result detection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_hold_reg #(
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_missed
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_missed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_missed <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            // An unconsumed result that is not accepted this edge is lost.
            if (r_valid && !i_ready) begin
                r_missed <= 1'b1;
            end
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data   = r_data;
    assign o_valid  = r_valid;
    assign o_missed = r_missed;

endmodule

`default_nettype wire

// File: rtl/pulse_period_meter.sv
// ============================================================================
//  Module      : pulse_period_meter
//  Description : Measures the interval in clock cycles between consecutive
//                pulses and presents each result on a valid/ready register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             pulse_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] period_o,
    output logic             overflow_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             missed_o
);

    localparam logic [WIDTH-1:0] C_SAT = WIDTH'(f_sat_value(WIDTH));
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    meter_state_e     r_state;
    meter_state_e     w_next_state;
    logic             w_capture;
    logic [WIDTH-1:0] r_count;
    logic             r_sat;
    logic [WIDTH:0]   w_payload;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (pulse_i) begin
                    w_next_state = MEASURE;
                end
            end
            MEASURE: begin
                w_capture = pulse_i;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Every pulse restarts the interval at 1, whether it locks or captures.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (pulse_i) begin
            r_count <= C_ONE;
            r_sat   <= 1'b0;
        end else if (r_state == MEASURE && r_count != C_SAT) begin
            r_count <= r_count + C_ONE;
            r_sat   <= ((r_count + C_ONE) == C_SAT);
        end
    end

    assign w_payload = {r_sat, r_count};

    result_hold_reg #(
        .DATA_W (WIDTH + 1)
    ) u_result_hold_reg (
        .clk      (clock_i),
        .rst_n    (reset_ni),
        .i_load   (w_capture),
        .i_data   (w_payload),
        .i_ready  (ready_i),
        .o_data   ({overflow_o, period_o}),
        .o_valid  (valid_o),
        .o_missed (missed_o)
    );

    assign locked_o = (r_state == MEASURE);

endmodule

`default_nettype wire

// File: tb/tb_pulse_period_meter.sv
// ============================================================================
//  Module      : tb_pulse_period_meter
//  Description : Directed self-checking bench for pulse_period_meter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_period_meter;

    logic       clock_i;
    logic       reset_ni;
    logic       pulse_i;
    logic       ready_i;
    logic [7:0] period_o;
    logic       overflow_o;
    logic       valid_o;
    logic       locked_o;
    logic       missed_o;

    int checks;
    int failures;

    pulse_period_meter #(
        .WIDTH (8)
    ) dut (
        .clock_i    (clock_i),
        .reset_ni   (reset_ni),
        .pulse_i    (pulse_i),
        .ready_i    (ready_i),
        .period_o   (period_o),
        .overflow_o (overflow_o),
        .valid_o    (valid_o),
        .locked_o   (locked_o),
        .missed_o   (missed_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // Advance one edge; outputs are sampled and inputs changed 1 ns later.
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic fire();
        pulse_i = 1'b1;
        tick();
        pulse_i = 1'b0;
    endtask

    // Idle cycles so that the next fire() lands n cycles after the last one.
    task automatic gap(input int n);
        pulse_i = 1'b0;
        repeat (n - 1) tick();
    endtask

    task automatic do_reset();
        pulse_i  = 1'b0;
        ready_i  = 1'b0;
        reset_ni = 1'b0;
        tick();
        tick();
        reset_ni = 1'b1;
    endtask

    task automatic check_result(input string name, input logic [7:0] exp_period,
                                input logic exp_ovf, input logic exp_valid,
                                input logic exp_missed);
        checks++;
        if ({period_o, overflow_o, valid_o, missed_o} !==
            {exp_period, exp_ovf, exp_valid, exp_missed}) begin
            failures++;
            $display("FAIL %s: period=%0d ovf=%0b valid=%0b missed=%0b, expected period=%0d ovf=%0b valid=%0b missed=%0b",
                     name, period_o, overflow_o, valid_o, missed_o,
                     exp_period, exp_ovf, exp_valid, exp_missed);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({period_o, overflow_o, valid_o, locked_o, missed_o} !== 12'd0) begin
            failures++;
            $display("FAIL reset_values: outputs=%h expected 000", {period_o, overflow_o, valid_o, locked_o, missed_o});
        end
        fire();
        checks++;
        if (locked_o !== 1'b1 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL first_pulse: locked=%0b valid=%0b expected locked=1 valid=0", locked_o, valid_o);
        end
        gap(5);
        fire();
        check_result("pre_reset_result", 8'd5, 1'b0, 1'b1, 1'b0);
        pulse_i = 1'b0;
        tick();
        tick();
        #2;
        reset_ni = 1'b0;
        #1;
        checks++;
        if ({period_o, overflow_o, valid_o, locked_o, missed_o} !== 12'd0) begin
            failures++;
            $display("FAIL async_reset: outputs=%h expected 000", {period_o, overflow_o, valid_o, locked_o, missed_o});
        end
        tick();
        reset_ni = 1'b1;
        fire();
        checks++;
        if (locked_o !== 1'b1 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL relock: locked=%0b valid=%0b expected locked=1 valid=0", locked_o, valid_o);
        end
        gap(4);
        fire();
        check_result("after_reset_period", 8'd4, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_pairing();
        do_reset();
        ready_i = 1'b1;
        fire();
        for (int i = 0; i < 3; i++) begin
            gap(16);
            fire();
            check_result("period16", 8'd16, 1'b0, 1'b1, 1'b0);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL period16_drain: valid=%0b expected 0", valid_o);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ready_i = 1'b1;
        pulse_i = 1'b1;
        tick();
        checks++;
        if (locked_o !== 1'b1 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_lock: locked=%0b valid=%0b expected locked=1 valid=0", locked_o, valid_o);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            check_result("b2b_result", 8'd1, 1'b0, 1'b1, 1'b0);
        end
        pulse_i = 1'b0;
        tick();
        check_result("b2b_drain", 8'd1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        do_reset();
        ready_i = 1'b1;
        fire();
        gap(300);
        fire();
        check_result("sat_300", 8'd255, 1'b1, 1'b1, 1'b0);
        gap(10);
        fire();
        check_result("after_sat_10", 8'd10, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        do_reset();
        ready_i = 1'b0;
        fire();
        gap(7);
        fire();
        check_result("bp_first", 8'd7, 1'b0, 1'b1, 1'b0);
        gap(9);
        check_result("bp_hold", 8'd7, 1'b0, 1'b1, 1'b0);
        fire();
        check_result("bp_overwrite", 8'd9, 1'b0, 1'b1, 1'b1);
        ready_i = 1'b1;
        tick();
        check_result("bp_accept", 8'd9, 1'b0, 1'b0, 1'b1);
        ready_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        ready_i = 1'b0;
        fire();
        gap(3);
        fire();
        check_result("sim_first", 8'd3, 1'b0, 1'b1, 1'b0);
        gap(5);
        ready_i = 1'b1;
        fire();
        ready_i = 1'b0;
        check_result("sim_capture_accept", 8'd5, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_ni = 1'b0;
        pulse_i  = 1'b0;
        ready_i  = 1'b0;
        test_reset();
        test_pairing();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
